// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a 1-cycle-latency sync FIFO into a valid/ready stream framed in bursts.
// Defining FIFO_RDR_CNT_EN adds the burst_cnt output counting completed bursts.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
`ifdef FIFO_RDR_CNT_EN
    output logic [15:0]           burst_cnt,
`endif
    output logic                  busy
);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pend_q, pend_d;
    logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  pop;
    logic                  issue_ok;
    logic [2:0]            fill;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return (v == CNT_LAST) ? '0 : v + CW'(1);
    endfunction

    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = buf0_q;
    assign out_last   = out_valid & (beat_cnt_q == CNT_LAST);
    assign busy       = (state_q != IDLE);
    assign pop        = out_valid & out_ready;
    assign issue_ok   = (state_q == RUN) || (state_q == STOP);
    // Occupancy after this cycle; a new read may only issue if its word will find a free slot.
    assign fill       = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign fifo_rd_en = issue_ok & ~fifo_empty & (fill < 3'd2);

    always_comb begin
        pend_d     = fifo_rd_en;
        iss_cnt_d  = fifo_rd_en ? wrap_inc(iss_cnt_q) : iss_cnt_q;
        beat_cnt_d = pop ? wrap_inc(beat_cnt_q) : beat_cnt_q;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        case ({pend_q, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) buf0_d = fifo_rd_data;
                else               buf1_d = fifo_rd_data;
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                buf0_d = buf1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Stop decisions look at the post-issue count so a stop never splits a burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = (iss_cnt_d == '0) ? DRAIN : STOP;
            STOP: begin
                if (enable)                 state_d = RUN;
                else if (iss_cnt_d == '0)   state_d = DRAIN;
            end
            DRAIN:   if (occ_q == 2'd0 && !pend_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            pend_q     <= 1'b0;
            iss_cnt_q  <= '0;
            beat_cnt_q <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            iss_cnt_q  <= iss_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_RDR_CNT_EN
    logic [15:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        burst_cnt_d = (pop & out_last) ? burst_cnt_q + 16'd1 : burst_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) burst_cnt_q <= 16'd0;
        else     burst_cnt_q <= burst_cnt_d;
    end

    assign burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: drives fifo_burst_reader from a behavioural sync FIFO and checks the
// stream against an in-order word queue with burst framing derived from the beat count.
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef FIFO_RDR_CNT_EN
    logic [15:0]   burst_cnt;
`endif

    logic [DW-1:0] mem [0:1023];
    logic [9:0]    wr_ptr = '0;
    logic [9:0]    rd_ptr = '0;
    logic          fifo_flush = 1'b0;

    logic [DW-1:0] exp_q[$];
    int            pop_count = 0;
    int            tests_run = 0;
    int            tests_failed = 0;

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
`ifdef FIFO_RDR_CNT_EN
        .burst_cnt   (burst_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Upstream sync FIFO: registered read data one cycle after an accepted read.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 10'd1;
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 10'd1;
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_flush = 1'b1;
        exp_q.delete();
        pop_count = 0;
        @(negedge clk);
        @(negedge clk);
        fifo_flush = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int stale;
        @(negedge clk);
        enable = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        for (int i = 0; i < 8; i++) push_word(DW'(8'hA0 + i));
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL midstream_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_rd_en: got %b expected 0", fifo_rd_en); end
        fifo_flush = 1'b1;
        exp_q.delete();
        pop_count = 0;
        repeat (2) @(negedge clk);
        fifo_flush = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        tests_run++; if (stale !== 0) begin tests_failed++; $display("[TB] FAIL no_stale_beat: got %0d beats expected 0", stale); end
    endtask

    task automatic test_full_throughput();
        logic [DW-1:0] exp_d;
        logic          exp_l;
        int            first;
        int            beats;
        int            gaps;
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(i * 17));
        enable = 1'b1; out_ready = 1'b1;
        first = -1; beats = 0; gaps = 0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                exp_d = exp_q.pop_front();
                exp_l = ((pop_count % BL) == BL - 1);
                pop_count++;
                tests_run++; if (out_data !== exp_d) begin tests_failed++; $display("[TB] FAIL thru_data: got %h expected %h", out_data, exp_d); end
                tests_run++; if (out_last !== exp_l) begin tests_failed++; $display("[TB] FAIL thru_last: got %b expected %b (data %h)", out_last, exp_l, exp_d); end
                if (first < 0) first = cyc;
                else if (cyc != first + beats) gaps++;
                beats++;
            end
        end
        tests_run++; if (beats !== 8) begin tests_failed++; $display("[TB] FAIL thru_count: got %0d beats expected 8", beats); end
        tests_run++; if (gaps !== 0) begin tests_failed++; $display("[TB] FAIL thru_rate: got %0d bubbles expected 0", gaps); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d;
        logic          exp_l;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic          prev_stall;
        int            beats;
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(i * 17));
        enable = 1'b1;
        beats = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 100 && beats < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            #1;
            if (prev_stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b", out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = ((pop_count % BL) == BL - 1);
                pop_count++;
                beats++;
                tests_run++; if (out_data !== exp_d) begin tests_failed++; $display("[TB] FAIL bp_data: got %h expected %h", out_data, exp_d); end
                tests_run++; if (out_last !== exp_l) begin tests_failed++; $display("[TB] FAIL bp_last: got %b expected %b", out_last, exp_l); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        tests_run++; if (beats !== 8) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d beats expected 8", beats); end
    endtask

    task automatic test_stop_boundary();
        logic [DW-1:0] exp_d;
        logic          exp_l;
        int            issued;
        int            beats;
        logic          done;
        logic          final_last;
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(8'h40 + i));
        enable = 1'b1; out_ready = 1'b1;
        issued = 0; beats = 0; done = 1'b0; final_last = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (issued >= 2) enable = 1'b0;
            #1;
            if (fifo_rd_en) issued++;
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = ((pop_count % BL) == BL - 1);
                pop_count++;
                beats++;
                final_last = out_last;
                tests_run++; if (out_data !== exp_d) begin tests_failed++; $display("[TB] FAIL stop_data: got %h expected %h", out_data, exp_d); end
                tests_run++; if (out_last !== exp_l) begin tests_failed++; $display("[TB] FAIL stop_last: got %b expected %b", out_last, exp_l); end
            end
            if (!enable && !busy) done = 1'b1;
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL stop_idle: got busy=%b expected busy=0 within bound", busy); end
        tests_run++; if (beats !== 4) begin tests_failed++; $display("[TB] FAIL stop_count: got %0d beats expected 4", beats); end
        tests_run++; if (final_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL stop_final_last: got %b expected 1", final_last); end
        tests_run++; if (10'(wr_ptr - rd_ptr) !== 10'd4) begin tests_failed++; $display("[TB] FAIL stop_fifo_left: got %0d words expected 4", 10'(wr_ptr - rd_ptr)); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] exp_d;
        logic          exp_l;
        int            beats;
        int            bad_rd;
        int            lasts;
        do_reset();
        enable = 1'b1; out_ready = 1'b1;
        bad_rd = 0; beats = 0; lasts = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en || out_valid) bad_rd++;
        end
        tests_run++; if (bad_rd !== 0) begin tests_failed++; $display("[TB] FAIL uf_idle_empty: got %0d active cycles expected 0", bad_rd); end
        @(negedge clk);
        push_word(8'h5A);
        push_word(8'hC3);
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc == 0) begin
                tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL uf_latency1: got %b expected 0", out_valid); end
            end
            if (cyc == 1) begin
                tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL uf_latency2: got %b expected 1", out_valid); end
            end
            if (fifo_empty && fifo_rd_en) bad_rd++;
            if (out_last) lasts++;
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = ((pop_count % BL) == BL - 1);
                pop_count++;
                beats++;
                tests_run++; if (out_data !== exp_d) begin tests_failed++; $display("[TB] FAIL uf_data: got %h expected %h", out_data, exp_d); end
                tests_run++; if (out_last !== exp_l) begin tests_failed++; $display("[TB] FAIL uf_last: got %b expected %b", out_last, exp_l); end
            end
        end
        tests_run++; if (beats !== 2) begin tests_failed++; $display("[TB] FAIL uf_count: got %0d beats expected 2", beats); end
        tests_run++; if (lasts !== 0) begin tests_failed++; $display("[TB] FAIL uf_no_last: got %0d last cycles expected 0", lasts); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL uf_valid_after: got %b expected 0", out_valid); end
        tests_run++; if (bad_rd !== 0) begin tests_failed++; $display("[TB] FAIL uf_rd_when_empty: got %0d reads expected 0", bad_rd); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        logic          exp_l;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic          prev_stall;
        int            bad_rd;
        int            cyc;
        do_reset();
        bad_rd = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        cyc = 0;
        while (cyc < 600 && (cyc < 300 || exp_q.size() != 0)) begin
            @(negedge clk);
            if (cyc < 300) begin
                out_ready = ($urandom_range(0, 3) != 0);
                enable    = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 2) == 0) push_word(DW'($urandom));
            end else begin
                out_ready = 1'b1;
                enable    = 1'b1;
            end
            #1;
            if (fifo_empty && fifo_rd_en) bad_rd++;
            if (prev_stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b", out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_extra_beat: got data %h expected no beat", out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_l = ((pop_count % BL) == BL - 1);
                    pop_count++;
                    if (out_data !== exp_d || out_last !== exp_l) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_beat: got d=%h l=%b expected d=%h l=%b", out_data, out_last, exp_d, exp_l);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            cyc++;
        end
        tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL rnd_drained: got %0d words pending expected 0", exp_q.size()); end
        tests_run++; if (bad_rd !== 0) begin tests_failed++; $display("[TB] FAIL rnd_rd_when_empty: got %0d reads expected 0", bad_rd); end
    endtask

`ifdef FIFO_RDR_CNT_EN
    task automatic test_burst_cnt();
        logic [DW-1:0] exp_d;
        int            beats;
        int            bursts;
        do_reset();
        #1;
        tests_run++; if (burst_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL bc_reset: got %0d expected 0", burst_cnt); end
        for (int i = 0; i < 16; i++) push_word(DW'($urandom));
        enable = 1'b1;
        beats = 0; bursts = 0;
        for (int cyc = 0; cyc < 200 && beats < 16; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                if ((pop_count % BL) == BL - 1) bursts++;
                pop_count++;
                beats++;
                tests_run++; if (out_data !== exp_d) begin tests_failed++; $display("[TB] FAIL bc_data: got %h expected %h", out_data, exp_d); end
            end
        end
        @(negedge clk);
        #1;
        tests_run++; if (beats !== 16) begin tests_failed++; $display("[TB] FAIL bc_count: got %0d beats expected 16", beats); end
        tests_run++; if (burst_cnt !== 16'(bursts) || bursts != 4) begin tests_failed++; $display("[TB] FAIL bc_value: got %0d expected 4", burst_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_throughput();
        test_backpressure();
        test_stop_boundary();
        test_underflow();
        test_random();
`ifdef FIFO_RDR_CNT_EN
        test_burst_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
